// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one multi-cycle ALU between two requesters.
// Latches the grantee's op/operands onto the ALU, waits the op latency, then returns the result with a one-cycle ack.
module alu_arbiter #(
  parameter int WORD     = 32,
  parameter int SEL_W    = 5,
  parameter int BASE_LAT = 2,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 34
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req0,
  input  logic [SEL_W-1:0] op0,
  input  logic [WORD-1:0]  a0,
  input  logic [WORD-1:0]  b0,
  output logic             ack0,
  input  logic             req1,
  input  logic [SEL_W-1:0] op1,
  input  logic [WORD-1:0]  a1,
  input  logic [WORD-1:0]  b1,
  output logic             ack1,
  output logic [WORD-1:0]  alu_a,
  output logic [WORD-1:0]  alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WORD-1:0]  alu_low,
  input  logic [WORD-1:0]  alu_high,
  output logic [WORD-1:0]  res_low,
  output logic [WORD-1:0]  res_high,
  output logic             busy,
  output logic             err
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);
  localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_MAX = SEL_W'(12);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // Counter load value: the capture edge lands exactly LAT edges after the grant edge.
  function automatic logic [CNT_W-1:0] lat_m1(input logic [SEL_W-1:0] op);
    if (op == OP_DIV)      return CNT_W'(DIV_LAT - 1);
    else if (op == OP_MUL) return CNT_W'(MUL_LAT - 1);
    else                   return CNT_W'(BASE_LAT - 1);
  endfunction

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_rr, w_rr;
  logic             r_gnt, w_gnt;
  logic [WORD-1:0]  r_alu_a, w_alu_a, r_alu_b, w_alu_b;
  logic [SEL_W-1:0] r_alu_sel, w_alu_sel;
  logic [WORD-1:0]  r_res_low, w_res_low, r_res_high, w_res_high;
  logic             r_ack0, w_ack0, r_ack1, w_ack1;
  logic             r_busy, w_busy, r_err, w_err;

  logic             w_pick;
  logic [SEL_W-1:0] w_op;
  logic [WORD-1:0]  w_a, w_b;

  // r_rr=1 prefers requester 1; otherwise requester 0 wins whenever it asks.
  assign w_pick = r_rr ? req1 : ~req0;
  assign w_op   = w_pick ? op1 : op0;
  assign w_a    = w_pick ? a1  : a0;
  assign w_b    = w_pick ? b1  : b0;

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_rr       = r_rr;
    w_gnt      = r_gnt;
    w_alu_a    = r_alu_a;
    w_alu_b    = r_alu_b;
    w_alu_sel  = r_alu_sel;
    w_res_low  = r_res_low;
    w_res_high = r_res_high;
    w_ack0     = 1'b0;
    w_ack1     = 1'b0;
    w_busy     = r_busy;
    w_err      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 || req1) begin
          w_gnt     = w_pick;
          w_alu_sel = w_op;
          w_alu_a   = w_a;
          w_alu_b   = w_b;
          w_busy    = 1'b1;
          if (w_op > OP_MAX) begin
            w_res_low  = '0;
            w_res_high = '0;
            w_err      = 1'b1;
            w_ack0     = ~w_pick;
            w_ack1     = w_pick;
            w_state    = DONE;
          end else begin
            w_cnt   = lat_m1(w_op);
            w_state = EXEC;
          end
        end
      end
      EXEC: begin
        if (r_cnt == '0) begin
          w_res_low  = alu_low;
          w_res_high = alu_high;
          w_ack0     = ~r_gnt;
          w_ack1     = r_gnt;
          w_state    = DONE;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        w_busy  = 1'b0;
        w_rr    = ~r_gnt;
        w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rr       <= 1'b0;
      r_gnt      <= 1'b0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_res_low  <= '0;
      r_res_high <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_rr       <= w_rr;
      r_gnt      <= w_gnt;
      r_alu_a    <= w_alu_a;
      r_alu_b    <= w_alu_b;
      r_alu_sel  <= w_alu_sel;
      r_res_low  <= w_res_low;
      r_res_high <= w_res_high;
      r_ack0     <= w_ack0;
      r_ack1     <= w_ack1;
      r_busy     <= w_busy;
      r_err      <= w_err;
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_sel  = r_alu_sel;
  assign res_low  = r_res_low;
  assign res_high = r_res_high;
  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU whose outputs are only valid after the op latency,
// directed cases plus randomised request patterns checked against a transaction-level model.
module tb_alu_arbiter;
  localparam int WORD     = 32;
  localparam int SEL_W    = 5;
  localparam int BASE_LAT = 2;
  localparam int MUL_LAT  = 4;
  localparam int DIV_LAT  = 34;

  logic        clk   = 1'b0;
  logic        clr_n = 1'b0;
  logic        req0  = 1'b0, req1 = 1'b0;
  logic [4:0]  op0   = 5'd0, op1 = 5'd0;
  logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
  logic        ack0, ack1, busy, err;
  logic [31:0] alu_a, alu_b, alu_low, alu_high, res_low, res_high;
  logic [4:0]  alu_sel;

  always #5 clk = ~clk;

  alu_arbiter #(.WORD(WORD), .SEL_W(SEL_W), .BASE_LAT(BASE_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .clr_n(clr_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_low(alu_low), .alu_high(alu_high),
    .res_low(res_low), .res_high(res_high),
    .busy(busy), .err(err)
  );

  typedef struct {
    int          who;
    logic [4:0]  op;
    logic [31:0] a, b, lo, hi;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0, cyc = 0, n_ack = 0, rr_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ALU behaviour as {high, low}; the arbiter just forwards these halves.
  function automatic logic [63:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (op)
      5'd0:    begin s = {1'b0, a} + {1'b0, b}; return {31'd0, s}; end
      5'd1:    return {32'd0, b - a};
      5'd2:    return (b == 32'd0) ? 64'd0 : {a % b, a / b};
      5'd3:    return {32'd0, a & b};
      5'd4:    return {32'd0, a | b};
      5'd5:    return {32'd0, a ^ b};
      5'd6:    return {32'd0, a} * {32'd0, b};
      5'd7:    return {32'd0, ~a};
      5'd8:    return {32'd0, a << b[4:0]};
      5'd9:    return {32'd0, a >> b[4:0]};
      5'd10:   return {32'd0, a + 32'd1};
      5'd11:   return {63'd0, a < b};
      5'd12:   return {63'd0, a == b};
      default: return {~a, ~b};
    endcase
  endfunction

  // Cycles from grant edge to capture edge; illegal ops complete on the grant edge itself.
  function automatic int model_lat(input logic [4:0] op);
    if (op > 5'd12)      return 0;
    else if (op == 5'd2) return DIV_LAT;
    else if (op == 5'd6) return MUL_LAT;
    else                 return BASE_LAT;
  endfunction

  function automatic int alu_need(input logic [4:0] op);
    if (op > 5'd12) return 1;
    return model_lat(op) - 1;
  endfunction

  // Behavioural ALU: result appears only once its inputs have been stable long enough.
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic [4:0]  m_sel = 5'd0;
  int          st_cnt = 0;

  always @(posedge clk) begin
    if (alu_a !== m_a || alu_b !== m_b || alu_sel !== m_sel) begin
      m_a <= alu_a; m_b <= alu_b; m_sel <= alu_sel; st_cnt <= 1;
    end else if (st_cnt < 100) begin
      st_cnt <= st_cnt + 1;
    end
  end

  always_comb begin
    if (st_cnt >= alu_need(m_sel)) {alu_high, alu_low} = alu_f(m_sel, m_a, m_b);
    else                           {alu_high, alu_low} = 64'hDEAD_BEEF_0BAD_F00D;
  end

  // Monitor: every ack is matched against the oldest expected transaction.
  always @(negedge clk) begin
    exp_t e;
    if (clr_n && (ack0 || ack1 || err)) begin
      n_ack++;
      chk("single_ack", 64'(ack0 & ack1), 64'd0);
      chk("err_needs_ack", 64'(err & ~(ack0 | ack1)), 64'd0);
      if (q.size() == 0) begin
        chk("spurious_ack", 64'({ack1, ack0}), 64'd0);
      end else begin
        e = q.pop_front();
        chk("ack_who", 64'(ack1 ? 1 : 0), 64'(e.who));
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("res_low", 64'(res_low), 64'(e.lo));
        chk("res_high", 64'(res_high), 64'(e.hi));
        chk("err_flag", 64'(err), 64'(e.err));
        chk("alu_sel_latched", 64'(alu_sel), 64'(e.op));
        chk("alu_ab_latched", {alu_a, alu_b}, {e.a, e.b});
        chk("busy_at_ack", 64'(busy), 64'd1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    #1;
    chk("rst_ctl", 64'({ack0, ack1, busy, err, alu_sel}), 64'd0);
    chk("rst_alu", {alu_a, alu_b}, 64'd0);
    chk("rst_res", {res_high, res_low}, 64'd0);
    rr_m = 0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  task automatic scenario(input bit e0, input bit e1,
                          input logic [4:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                          input logic [4:0] o1, input logic [31:0] x1, input logic [31:0] y1,
                          input bit drop, input bit scr);
    int n0, first, t, bsy_n, bsy_exp, k;
    exp_t e;
    logic [63:0] r;
    logic [31:0] last_lo;
    @(negedge clk);
    if (e0) begin op0 = o0; a0 = x0; b0 = y0; req0 = 1'b1; end
    if (e1) begin op1 = o1; a1 = x1; b1 = y1; req1 = 1'b1; end
    n0      = cyc + 1;
    first   = (e0 && e1) ? rr_m : (e1 ? 1 : 0);
    t       = n0;
    bsy_exp = 0;
    last_lo = 32'd0;
    for (int g = 0; g < ((e0 && e1) ? 2 : 1); g++) begin
      e.who = (g == 0) ? first : 1 - first;
      e.op  = (e.who == 1) ? o1 : o0;
      e.a   = (e.who == 1) ? x1 : x0;
      e.b   = (e.who == 1) ? y1 : y0;
      if (g == 1) t = t + 2;
      t     = t + model_lat(e.op);
      e.cyc = t;
      e.err = (e.op > 5'd12);
      r     = e.err ? 64'd0 : alu_f(e.op, e.a, e.b);
      e.hi  = r[63:32];
      e.lo  = r[31:0];
      q.push_back(e);
      rr_m    = 1 - e.who;
      bsy_exp = bsy_exp + model_lat(e.op) + 1;
      last_lo = e.lo;
    end
    bsy_n = 0;
    for (k = 0; k < 200 && q.size() != 0; k++) begin
      @(negedge clk);
      if (busy) bsy_n++;
      if (cyc == n0) begin
        if (scr && first == 0) begin op0 = 5'($urandom); a0 = $urandom; b0 = $urandom; end
        if (scr && first == 1) begin op1 = 5'($urandom); a1 = $urandom; b1 = $urandom; end
        if (drop) begin
          if (first == 0) req0 = 1'b0;
          else            req1 = 1'b0;
        end
      end
      if (ack0) req0 = 1'b0;
      if (ack1) req1 = 1'b0;
    end
    chk("ack_timeout", 64'(q.size()), 64'd0);
    if (q.size() != 0) begin
      q.delete();
      do_reset();
    end else begin
      chk("busy_cycles", 64'(bsy_n), 64'(bsy_exp));
      repeat (2) @(negedge clk);
      chk("idle_quiet", 64'({busy, ack0, ack1, err}), 64'd0);
      chk("res_hold", 64'(res_low), 64'(last_lo));
    end
  endtask

  function automatic logic [4:0] rand_op();
    int r;
    r = $urandom_range(0, 19);
    if (r < 13) return 5'(r);
    return 5'($urandom_range(13, 31));
  endfunction

  function automatic logic [31:0] rand_val();
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 15));
    return $urandom;
  endfunction

  initial begin
    int n0, acks_before, sel;
    do_reset();

    // 1: single add
    scenario(1, 0, 5'd0, 32'd5, 32'd7, 5'd0, 32'd0, 32'd0, 0, 0);
    chk("t1_res", {res_high, res_low}, 64'd12);

    // 2: simultaneous subtracts, pointer fresh from reset
    do_reset();
    scenario(1, 1, 5'd1, 32'd4, 32'd9, 5'd1, 32'd5, 32'd20, 0, 0);
    chk("t2_res_last", 64'(res_low), 64'd15);

    // 3: multiply on requester 1
    scenario(0, 1, 5'd0, 32'd0, 32'd0, 5'd6, 32'h0001_0000, 32'h0001_0000, 0, 0);
    chk("t3_res", {res_high, res_low}, 64'h0000_0001_0000_0000);

    // 4: illegal op
    scenario(1, 0, 5'd13, 32'd3, 32'd4, 5'd0, 32'd0, 32'd0, 0, 0);
    chk("t4_res", {res_high, res_low}, 64'd0);
    chk("t4_sel", 64'(alu_sel), 64'd13);

    // 5: abort a divide with reset; pointer must come back to requester 0
    scenario(1, 0, 5'd3, 32'hF0, 32'h3C, 5'd0, 32'd0, 32'd0, 0, 0);
    @(negedge clk);
    req0 = 1'b1; op0 = 5'd2; a0 = 32'd100; b0 = 32'd7;
    n0 = cyc + 1;
    while (cyc < n0 + 9) @(negedge clk);
    chk("t5_busy_mid_div", 64'(busy), 64'd1);
    acks_before = n_ack;
    #2 clr_n = 1'b0;
    #1;
    chk("t5_abort_ctl", 64'({ack0, ack1, busy, err, alu_sel}), 64'd0);
    chk("t5_abort_alu", {alu_a, alu_b}, 64'd0);
    chk("t5_abort_res", {res_high, res_low}, 64'd0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    rr_m  = 0;
    repeat (40) @(negedge clk);
    chk("t5_no_ack_after_abort", 64'(n_ack - acks_before), 64'd0);
    scenario(1, 1, 5'd5, 32'd6, 32'd3, 5'd4, 32'd8, 32'd1, 0, 0);
    scenario(0, 1, 5'd0, 32'd0, 32'd0, 5'd0, 32'd1, 32'd1, 0, 0);
    chk("t5_res_after", 64'(res_low), 64'd2);

    // 6: requester drops its request right after the grant
    scenario(0, 1, 5'd0, 32'd0, 32'd0, 5'd4, 32'h0F0, 32'h00F, 1, 0);
    chk("t6_res", 64'(res_low), 64'h0FF);

    // Randomised traffic
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      scenario(sel != 1, sel != 0,
               rand_op(), rand_val(), rand_val(),
               rand_op(), rand_val(), rand_val(),
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
